// File: rtl/pri_event_encoder_pkg.sv
// Shared types and helpers for the priority event encoder.
// Optional input mask is enabled with PRI_EVENT_MASK_EN.
package pri_event_pkg;

  localparam int N_DEF = 8;

  function automatic int clog2_f(int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic [63:0] onehot_f(int idx, int n);
    logic [63:0] v;
    v = '0;
    if (idx < n) v = 64'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/pri_event_encoder_if.sv
// Code/valid/ready handshake between encoder and consumer.
// Width W follows the encoder's line count.
interface pri_event_encoder_if
  import pri_event_pkg::*;
#(
  parameter int W = clog2_f(N_DEF)
);

  logic [W-1:0] code;
  logic         valid;
  logic         ready;

  modport master (
    output code,
    output valid,
    input  ready
  );

  modport slave (
    input  code,
    input  valid,
    output ready
  );

endinterface

// File: rtl/pri_event_encoder_comb.sv
// Combinational highest-index-wins encoder.
// No state; feeds the output register of the top.
module pri_enc_comb
  import pri_event_pkg::*;
#(
  parameter  int N = N_DEF,
  localparam int W = clog2_f(N)
) (
  input  logic [N-1:0] in_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (in_i[i]) idx_o = W'(i);
    end
  end

  assign any_o = |in_i;

endmodule

// File: rtl/pri_event_encoder.sv
// Edge-capturing priority event encoder with registered code output.
// Define PRI_EVENT_MASK_EN to add the mask input.
module pri_event_encoder
  import pri_event_pkg::*;
#(
  parameter  int N = N_DEF,
  localparam int W = clog2_f(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] pend,
  output logic         ovf,
  input  logic         ovf_clr,
`ifdef PRI_EVENT_MASK_EN
  input  logic [N-1:0] mask,
`endif
  pri_event_encoder_if.master evt
);

  logic [N-1:0] req_q;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] code_q;
  logic         valid_q;
  logic         ovf_q, ovf_d;

  logic [N-1:0] rise;
  logic [N-1:0] pend_eff;
  logic [N-1:0] take;
  logic [N-1:0] oh;
  logic [W-1:0] idx;
  logic         any;
  logic         load;
  logic         ovf_set;

  assign rise = req & ~req_q;

`ifdef PRI_EVENT_MASK_EN
  assign pend_eff = pend_q & ~mask;
`else
  assign pend_eff = pend_q;
`endif

  pri_enc_comb #(.N(N)) u_enc (
    .in_i  (pend_eff),
    .idx_o (idx),
    .any_o (any)
  );

  assign load = (!valid_q || evt.ready) && any;
  assign oh   = N'(onehot_f(int'(idx), N));
  assign take = load ? oh : '0;

  // A fresh rise on the line being taken survives as a new event.
  assign pend_d  = (pend_q & ~take) | (en ? rise : '0);
  assign ovf_set = en && |(rise & pend_q & ~take);
  assign ovf_d   = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      req_q  <= req;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      if (!valid_q || evt.ready) begin
        if (any) begin
          code_q  <= idx;
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign evt.code  = code_q;
  assign evt.valid = valid_q;
  assign pend      = pend_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pri_event_encoder.sv
// Scoreboard bench for pri_event_encoder, N=8.
// Mask scenario runs only when PRI_EVENT_MASK_EN is defined.
module tb_pri_event_encoder;
  import pri_event_pkg::*;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en;
  logic [N-1:0] req;
  logic [N-1:0] pend;
  logic         ovf;
  logic         ovf_clr;
`ifdef PRI_EVENT_MASK_EN
  logic [N-1:0] mask;
`endif

  pri_event_encoder_if #(.W(W)) evt ();

  pri_event_encoder #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .pend    (pend),
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
`ifdef PRI_EVENT_MASK_EN
    .mask    (mask),
`endif
    .evt     (evt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake completes at the next rising edge; check the code here.
  always @(negedge clk) begin
    if (rst_n && evt.valid && evt.ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 64'(evt.code), 64'hDEAD);
      end else begin
        chk("sb_code", 64'(evt.code), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    en        = 1'b1;
    req       = 8'hFF;
    ovf_clr   = 1'b0;
    evt.ready = 1'b0;
`ifdef PRI_EVENT_MASK_EN
    mask = '0;
`endif
    #1 rst_n = 1'b0;
    step();
    step();
    chk("rst_valid", 64'(evt.valid), 64'd0);
    chk("rst_pend", 64'(pend), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);

    // 1: lines held high through reset release
    rst_n = 1'b1;
    for (int i = 7; i >= 0; i--) exp_q.push_back(W'(i));
    step();
    chk("t1_pend", 64'(pend), 64'hFF);
    chk("t1_valid0", 64'(evt.valid), 64'd0);
    step();
    chk("t1_code", 64'(evt.code), 64'd7);
    chk("t1_valid", 64'(evt.valid), 64'd1);
    chk("t1_pend_take", 64'(pend), 64'h7F);
    req = '0;
    evt.ready = 1'b1;
    repeat (10) step();
    chk("t1_drain_valid", 64'(evt.valid), 64'd0);
    chk("t1_drain_pend", 64'(pend), 64'd0);

    // 2: priority drain
    req = 8'b0010_0101;
    exp_q.push_back(W'(5));
    exp_q.push_back(W'(2));
    exp_q.push_back(W'(0));
    step();
    req = '0;
    step();
    chk("t2_c5", 64'(evt.code), 64'd5);
    step();
    chk("t2_c2", 64'(evt.code), 64'd2);
    step();
    chk("t2_c0", 64'(evt.code), 64'd0);
    step();
    chk("t2_valid", 64'(evt.valid), 64'd0);
    chk("t2_pend", 64'(pend), 64'd0);

    // 3: stall while a higher line arrives
    evt.ready = 1'b0;
    req = 8'h08;
    exp_q.push_back(W'(3));
    step();
    req = '0;
    step();
    chk("t3_code", 64'(evt.code), 64'd3);
    req = 8'h40;
    exp_q.push_back(W'(6));
    step();
    req = '0;
    repeat (4) step();
    chk("t3_hold_code", 64'(evt.code), 64'd3);
    chk("t3_hold_valid", 64'(evt.valid), 64'd1);
    chk("t3_pend6", 64'(pend[6]), 64'd1);
    evt.ready = 1'b1;
    step();
    chk("t3_c6", 64'(evt.code), 64'd6);
    step();
    chk("t3_valid", 64'(evt.valid), 64'd0);

    // 4: overrun on a line that is still pending
    evt.ready = 1'b0;
    req = 8'h02;
    exp_q.push_back(W'(1));
    step();
    req = '0;
    step();
    chk("t4_busy", 64'(evt.code), 64'd1);
    req = 8'h10;
    exp_q.push_back(W'(4));
    step();
    req = '0;
    step();
    step();
    chk("t4_no_ovf", 64'(ovf), 64'd0);
    req = 8'h10;
    step();
    chk("t4_ovf", 64'(ovf), 64'd1);
    chk("t4_pend4", 64'(pend[4]), 64'd1);
    req = '0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 64'(ovf), 64'd0);
    evt.ready = 1'b1;
    step();
    chk("t4_c4", 64'(evt.code), 64'd4);
    step();
    chk("t4_valid", 64'(evt.valid), 64'd0);

    // 5: edges during en=0 are dropped, not deferred
    en = 1'b0;
    req = 8'h02;
    step();
    step();
    chk("t5_pend", 64'(pend), 64'd0);
    chk("t5_valid", 64'(evt.valid), 64'd0);
    en = 1'b1;
    step();
    step();
    chk("t5_en_pend", 64'(pend), 64'd0);
    chk("t5_en_valid", 64'(evt.valid), 64'd0);
    req = '0;
    step();

`ifdef PRI_EVENT_MASK_EN
    // 6: masked line stays pending until unmasked
    mask = 8'h80;
    req = 8'h84;
    exp_q.push_back(W'(2));
    exp_q.push_back(W'(7));
    step();
    req = '0;
    step();
    chk("t6_c2", 64'(evt.code), 64'd2);
    chk("t6_pend7", 64'(pend[7]), 64'd1);
    mask = '0;
    step();
    chk("t6_c7", 64'(evt.code), 64'd7);
    step();
    chk("t6_valid", 64'(evt.valid), 64'd0);
`endif

    step();
    chk("sb_left", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
